// File: rtl/ex_seqdet_pkg.sv
// Shared constants and types for the programmable sequence detector.
package ex_seqdet_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W     = $clog2(PAT_W_DEF + 1);

  // Default pattern 0,1,0,0,1 (oldest first) in the low DEF_LEN bits.
  localparam logic [PAT_W_DEF-1:0] DEF_PAT = 8'h09;
  localparam int                   DEF_LEN = 5;

  // Configuration bundle as presented by the control block.
  typedef struct packed {
    logic [PAT_W_DEF-1:0] pat;
    logic [LEN_W-1:0]     len;
    logic                 ovl;
  } cfg_t;

endpackage

// File: rtl/ex_seqdet_win.sv
// Sliding window: history shift register, fill counter and masked compare.
// Produces a combinational hit for the bit presented this cycle.
module ex_seqdet_win #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic             i_din,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_ovl,
  output logic             o_hit
);

  // The oldest history bit would shift straight out without ever being
  // compared, so only PAT_W-1 bits are stored; the new bit completes the window.
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [PAT_W-1:0] w_win;
  logic [PAT_W-1:0] w_mask;
  logic             w_armed;
  logic             w_eq;

  assign w_win = {r_hist, i_din};

  // Select the low i_len bits of the window for comparison.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  // Enough valid bits have arrived once this one completes the pattern.
  assign w_armed = (({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, i_len});
  assign w_eq    = (((w_win ^ i_pat) & w_mask) == '0);
  assign o_hit   = i_vld && !i_clr && (i_len != '0) && w_armed && w_eq;

  // History shift and fill tracking; a config load restarts both.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_vld) begin
      r_hist <= w_win[PAT_W-2:0];
      if (o_hit && !i_ovl) begin
        r_fill <= '0;
      end else if (r_fill < i_len) begin
        r_fill <= r_fill + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/ex_seqdet_prog.sv
// Programmable serial sequence detector: config shadow, registered match
// pulse and saturating match counter around the sliding-window matcher.
module ex_seqdet_prog
  import ex_seqdet_pkg::*;
#(
  parameter int                PAT_W   = PAT_W_DEF,
  parameter int                CNT_W   = 16,
  parameter logic [PAT_W-1:0]  DEF_PAT = ex_seqdet_pkg::DEF_PAT,
  parameter int                DEF_LEN = ex_seqdet_pkg::DEF_LEN
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic                         cin,
  input  logic                         cin_vld,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             pat,
  input  logic [$clog2(PAT_W+1)-1:0]   pat_len,
  input  logic                         overlap_en,
  input  logic                         cnt_clr,
  output logic                         cout,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int LW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] r_pat;
  logic [LW-1:0]    r_len;
  logic             r_ovl;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic [LW-1:0]    w_len_ld;
  logic             w_hit;

  // Lengths beyond the window are clamped to the full window.
  always_comb begin
    w_len_ld = pat_len;
    if (int'(pat_len) > PAT_W) begin
      w_len_ld = LW'(PAT_W);
    end
  end

  // Config shadow, only written by a load pulse.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= DEF_PAT;
      r_len <= LW'(DEF_LEN);
      r_ovl <= 1'b1;
    end else if (cfg_load) begin
      r_pat <= pat;
      r_len <= w_len_ld;
      r_ovl <= overlap_en;
    end
  end

  ex_seqdet_win #(
    .PAT_W (PAT_W),
    .LEN_W (LW)
  ) u_win (
    .sclk  (sclk),
    .rst_n (rst_n),
    .i_clr (cfg_load),
    .i_vld (cin_vld),
    .i_din (cin),
    .i_pat (r_pat),
    .i_len (r_len),
    .i_ovl (r_ovl),
    .o_hit (w_hit)
  );

  // Registered match pulse and saturating counter; clear beats increment.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_cout <= w_hit;
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_hit && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign cout      = r_cout;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_ex_seqdet_prog.sv
// Bench for ex_seqdet_prog: a behavioural model pushes the expected outputs of
// every driven cycle into a queue; each test pops and compares after the edge.
module tb_ex_seqdet_prog;
  import ex_seqdet_pkg::*;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cin = 1'b0, cin_vld = 1'b0, cfg_load = 1'b0, cnt_clr = 1'b0;
  logic [7:0]  pat = '0;
  logic [3:0]  pat_len = '0;
  logic        overlap_en = 1'b0;
  logic        cout, cout_s;
  logic [15:0] match_cnt;
  logic [1:0]  match_cnt_s;

  typedef struct packed {
    logic        cout;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // model state
  logic [7:0] m_pat, m_hist;
  int         m_len, m_fill, m_cnt, m_cnt2;
  logic       m_ovl;

  always #5 sclk = ~sclk;

  ex_seqdet_prog dut (
    .sclk(sclk), .rst_n(rst_n), .cin(cin), .cin_vld(cin_vld), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .cout(cout), .match_cnt(match_cnt)
  );

  ex_seqdet_prog #(.CNT_W(2)) dut_s (
    .sclk(sclk), .rst_n(rst_n), .cin(cin), .cin_vld(cin_vld), .cfg_load(cfg_load),
    .pat(pat), .pat_len(pat_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
    .cout(cout_s), .match_cnt(match_cnt_s)
  );

  task automatic model_reset();
    m_pat = 8'h09; m_len = 5; m_ovl = 1'b1;
    m_hist = '0; m_fill = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  // Drive one cycle, update the model, push expectation, step past the edge.
  task automatic cycle(input logic vld, input logic b, input logic ld, input logic clr);
    exp_t       e;
    logic [7:0] win, mask;
    logic       hit;
    cin_vld = vld; cin = b; cfg_load = ld; cnt_clr = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat  = pat;
      m_len  = (int'(pat_len) > 8) ? 8 : int'(pat_len);
      m_ovl  = overlap_en;
      m_hist = '0;
      m_fill = 0;
    end else if (vld) begin
      win = {m_hist[6:0], b};
      for (int i = 0; i < 8; i++) mask[i] = (i < m_len);
      hit = (m_len != 0) && (m_fill + 1 >= m_len) && (((win ^ m_pat) & mask) == 8'h00);
      m_hist = win;
      if (hit && !m_ovl) m_fill = 0;
      else if (m_fill < m_len) m_fill = m_fill + 1;
    end
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt != 65535) m_cnt = m_cnt + 1;
      if (m_cnt2 != 3) m_cnt2 = m_cnt2 + 1;
    end
    e.cout = hit; e.cnt = m_cnt[15:0]; e.cnt2 = m_cnt2[1:0];
    sb_q.push_back(e);
    @(posedge sclk); #1;
    cin_vld = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; cin = 1'b0;
  endtask

  task automatic load_cfg(input cfg_t c);
    pat = c.pat; pat_len = c.len; overlap_en = c.ovl;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    void'(sb_q.pop_front());
  endtask

  task automatic clear_cnt();
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    void'(sb_q.pop_front());
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1;
    n_chk++;
    if (cout !== 1'b0 || cout_s !== 1'b0) begin
      n_err++; $display("FAIL reset_cout got=%b/%b want=0", cout, cout_s);
    end
    n_chk++;
    if (match_cnt !== 16'd0 || match_cnt_s !== 2'd0) begin
      n_err++; $display("FAIL reset_cnt got=%0d/%0d want=0", match_cnt, match_cnt_s);
    end
    @(negedge sclk); rst_n = 1'b1;
    @(posedge sclk); #1;
    model_reset();
  endtask

  task automatic test_default();
    logic [4:0] bits;
    exp_t e;
    int   pulses, last;
    bits = 5'b01001; pulses = 0; last = -1;
    for (int i = 4; i >= 0; i--) begin
      cycle(1'b1, bits[i], 1'b0, 1'b0);
      e = sb_q.pop_front();
      n_chk++;
      if ({cout, cout_s, match_cnt, match_cnt_s} !== {e.cout, e.cout, e.cnt, e.cnt2}) begin
        n_err++;
        $display("FAIL default bit%0d got cout=%b/%b cnt=%0d/%0d want cout=%b cnt=%0d/%0d",
                 4 - i, cout, cout_s, match_cnt, match_cnt_s, e.cout, e.cnt, e.cnt2);
      end
      if (cout === 1'b1) begin pulses++; last = 4 - i; end
    end
    n_chk++;
    if (pulses !== 1 || last !== 4 || match_cnt !== 16'd1) begin
      n_err++; $display("FAIL default_total got pulses=%0d at=%0d cnt=%0d want 1 at 4 cnt 1", pulses, last, match_cnt);
    end
  endtask

  task automatic test_overlap(input logic ovl, input int want_p);
    logic [4:0] bits;
    exp_t e;
    int   pulses;
    cfg_t c;
    bits = 5'b10101; pulses = 0;
    clear_cnt();
    c.pat = 8'b101; c.len = 4'd3; c.ovl = ovl;
    load_cfg(c);
    for (int i = 4; i >= 0; i--) begin
      cycle(1'b1, bits[i], 1'b0, 1'b0);
      e = sb_q.pop_front();
      n_chk++;
      if ({cout, cout_s, match_cnt, match_cnt_s} !== {e.cout, e.cout, e.cnt, e.cnt2}) begin
        n_err++;
        $display("FAIL overlap%0b bit%0d got cout=%b cnt=%0d/%0d want cout=%b cnt=%0d/%0d",
                 ovl, 4 - i, cout, match_cnt, match_cnt_s, e.cout, e.cnt, e.cnt2);
      end
      if (cout === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== want_p || match_cnt !== 16'(want_p)) begin
      n_err++; $display("FAIL overlap%0b_total got pulses=%0d cnt=%0d want %0d", ovl, pulses, match_cnt, want_p);
    end
  endtask

  task automatic test_gaps();
    logic [2:0] bits;
    exp_t e;
    int   pulses, cyc, last;
    cfg_t c;
    bits = 3'b101; pulses = 0; cyc = 0; last = -1;
    clear_cnt();
    c.pat = 8'b101; c.len = 4'd3; c.ovl = 1'b1;
    load_cfg(c);
    for (int i = 2; i >= 0; i--) begin
      for (int g = 0; g < 4; g++) begin
        if (g == 3) cycle(1'b1, bits[i], 1'b0, 1'b0);
        else        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        e = sb_q.pop_front();
        n_chk++;
        if ({cout, match_cnt, match_cnt_s} !== {e.cout, e.cnt, e.cnt2}) begin
          n_err++;
          $display("FAIL gaps cyc%0d got cout=%b cnt=%0d want cout=%b cnt=%0d", cyc, cout, match_cnt, e.cout, e.cnt);
        end
        if (cout === 1'b1) begin pulses++; last = cyc; end
        cyc++;
      end
    end
    n_chk++;
    if (pulses !== 1 || last !== 11 || match_cnt !== 16'd1) begin
      n_err++; $display("FAIL gaps_total got pulses=%0d at=%0d cnt=%0d want 1 at 11 cnt 1", pulses, last, match_cnt);
    end
  endtask

  task automatic test_load_collision();
    // vld, bit, load per step: 1,0 then load+valid 1, then fresh 1,0,1
    logic [5:0] v, b, l;
    exp_t e;
    int   pulses, last;
    cfg_t c;
    v = 6'b111111; b = 6'b101101; l = 6'b001000; pulses = 0; last = -1;
    clear_cnt();
    c.pat = 8'b101; c.len = 4'd3; c.ovl = 1'b1;
    load_cfg(c);
    for (int i = 5; i >= 0; i--) begin
      cycle(v[i], b[i], l[i], 1'b0);
      e = sb_q.pop_front();
      n_chk++;
      if ({cout, match_cnt} !== {e.cout, e.cnt}) begin
        n_err++;
        $display("FAIL collide step%0d got cout=%b cnt=%0d want cout=%b cnt=%0d", 5 - i, cout, match_cnt, e.cout, e.cnt);
      end
      if (cout === 1'b1) begin pulses++; last = 5 - i; end
    end
    n_chk++;
    if (pulses !== 1 || last !== 5) begin
      n_err++; $display("FAIL collide_total got pulses=%0d at=%0d want 1 at 5", pulses, last);
    end
  endtask

  task automatic test_back_to_back_sat();
    exp_t e;
    int   pulses;
    cfg_t c;
    pulses = 0;
    clear_cnt();
    c.pat = 8'h01; c.len = 4'd1; c.ovl = 1'b1;
    load_cfg(c);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      e = sb_q.pop_front();
      n_chk++;
      if ({cout, cout_s, match_cnt, match_cnt_s} !== {e.cout, e.cout, e.cnt, e.cnt2}) begin
        n_err++;
        $display("FAIL sat bit%0d got cout=%b cnt=%0d/%0d want cout=%b cnt=%0d/%0d",
                 i, cout, match_cnt, match_cnt_s, e.cout, e.cnt, e.cnt2);
      end
      if (cout === 1'b1 && cout_s === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 6 || match_cnt_s !== 2'd3 || match_cnt !== 16'd6) begin
      n_err++; $display("FAIL sat_total got pulses=%0d cnt2=%0d cnt=%0d want 6,3,6", pulses, match_cnt_s, match_cnt);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    e = sb_q.pop_front();
    n_chk++;
    if (cout !== 1'b1 || match_cnt !== 16'd0 || match_cnt_s !== 2'd0 || e.cout !== 1'b1) begin
      n_err++; $display("FAIL clr_vs_match got cout=%b cnt=%0d/%0d want cout=1 cnt=0/0", cout, match_cnt, match_cnt_s);
    end
  endtask

  task automatic test_clamp_and_zero();
    logic [7:0] bits;
    exp_t e;
    int   pulses;
    cfg_t c;
    bits = 8'hA5; pulses = 0;
    c.pat = 8'hA5; c.len = 4'd15; c.ovl = 1'b1;
    load_cfg(c);
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b1, bits[i], 1'b0, 1'b0);
      e = sb_q.pop_front();
      n_chk++;
      if ({cout, match_cnt} !== {e.cout, e.cnt}) begin
        n_err++; $display("FAIL clamp bit%0d got cout=%b cnt=%0d want cout=%b cnt=%0d", 7 - i, cout, match_cnt, e.cout, e.cnt);
      end
      if (cout === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 1 || cout !== 1'b1) begin
      n_err++; $display("FAIL clamp_total got pulses=%0d last=%b want 1 on final bit", pulses, cout);
    end
    c.pat = 8'h00; c.len = 4'd0; c.ovl = 1'b1;
    load_cfg(c);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      e = sb_q.pop_front();
      if (cout === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 0 || match_cnt !== 16'd1 || e.cnt !== 16'd1) begin
      n_err++; $display("FAIL len0 got pulses=%0d cnt=%0d want 0 pulses cnt 1", pulses, match_cnt);
    end
  endtask

  task automatic test_midstream_reset();
    logic [3:0] bits;
    exp_t e;
    cfg_t c;
    bits = 4'b0100;
    c.pat = 8'h09; c.len = 4'd5; c.ovl = 1'b1;
    load_cfg(c);
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b1, bits[i], 1'b0, 1'b0);
      void'(sb_q.pop_front());
    end
    rst_n = 1'b0;
    #2;
    n_chk++;
    if (cout !== 1'b0 || match_cnt !== 16'd0 || match_cnt_s !== 2'd0) begin
      n_err++; $display("FAIL midreset got cout=%b cnt=%0d/%0d want 0", cout, match_cnt, match_cnt_s);
    end
    model_reset();
    @(negedge sclk); rst_n = 1'b1;
    @(posedge sclk); #1;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    e = sb_q.pop_front();
    n_chk++;
    if (cout !== 1'b0 || match_cnt !== 16'd0 || e.cout !== 1'b0) begin
      n_err++; $display("FAIL after_reset got cout=%b cnt=%0d want cout=0 cnt=0", cout, match_cnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_default();
    test_overlap(1'b1, 2);
    test_overlap(1'b0, 1);
    test_gaps();
    test_load_collision();
    test_back_to_back_sat();
    test_clamp_and_zero();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_seqdet_prog.md
# ex_seqdet_prog

Programmable serial sequence detector, the parametrised successor to the fixed-pattern FSM detector. It watches a 1-bit serial stream qualified by a valid strobe and compares it against a runtime-loaded pattern of up to `PAT_W` bits. It emits a one-cycle `cout` pulse per match, in either overlapping or non-overlapping mode, and keeps a saturating match counter. It sits directly behind the serial input stage, with configuration driven by the control block.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 16: match counter width.
- `DEF_PAT`, 8'h09: reset pattern. Bits 0,1,0,0,1 arrive oldest-first.
- `DEF_LEN`, 5: reset pattern length.
- `sclk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cin`  in  1  serial data bit.
- `cin_vld`  in  1  `cin` is sampled only when high.
- `cfg_load`  in  1  one-cycle pulse; latches `pat`, `pat_len` and `overlap_en`.
- `pat`  in  PAT_W  pattern. `pat[pat_len-1]` is the oldest bit and `pat[0]` the newest.
- `pat_len`  in  $clog2(PAT_W+1)  active pattern length.
- `overlap_en`  in  1  1 = overlapping matches allowed.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `cout`  out  1  registered match pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.

## Operation
- **Config shadow** holds `pat_q`, `len_q` and `ovl_q`.
  - Reset values: `DEF_PAT`, `DEF_LEN`, 1.
  - Loaded only on `cfg_load`; the input pins are ignored at other times.
  - A loaded `pat_len` > `PAT_W` clamps to `PAT_W`.
  - `len_q` = 0 disables detection: no `cout`, and the counter holds.
- **History**: a `PAT_W`-bit shift register `hist`. On each sampled bit, `hist <= {hist[PAT_W-2:0], cin}`.
- **Fill counter** `fill` (0..`PAT_W`) counts valid bits since the last clear.
  - Increments on each sampled bit and saturates at `len_q`.
  - Unsampled bits are not counted.
- **Match condition**, evaluated on the post-shift window:
  - `cin_vld`, `len_q` ≠ 0, and `fill + 1 >= len_q`;
  - and the low `len_q` bits of `{hist[PAT_W-2:0], cin}` equal the low `len_q` bits of `pat_q`.
- **After a match**:
  - `ovl_q` = 1: `fill` stays at `len_q`.
  - `ovl_q` = 0: `fill` clears to 0, so the next match needs `len_q` fresh bits.
- **Clears**:
  - `cfg_load` clears `hist` and `fill`. `match_cnt` is unaffected.
  - Reset clears all state.
- **States** (for the verifier's model): derived from `fill`.
  - `IDLE` (`fill` = 0) → `FILL` (0 < `fill` < `len_q`) → `ARMED` (`fill` = `len_q`).
  - `ARMED` → `IDLE` on a non-overlap match.
  - Any state → `IDLE` on `cfg_load`.
- **Counter**: `match_cnt` increments by 1 per match and saturates at 2^CNT_W−1.

## Timing
- Reset values: `cout` = 0, `match_cnt` = 0, `hist` = 0, `fill` = 0, shadow = defaults.
- Latency: `cout` is high for exactly the one cycle following the edge that samples the completing bit. `match_cnt` updates on that same edge.
- Back-to-back overlapping matches give `cout` high on consecutive cycles.
- `cin_vld` low: `hist` and `fill` hold, and `cout` = 0 the next cycle.
- Simultaneous events:
  - `cfg_load` with `cin_vld`: `cfg_load` wins. The bit is discarded and no match is evaluated. The new config is active from the next edge.
  - `cnt_clr` with a match: the clear wins, so `match_cnt` = 0. `cout` still pulses.
- Reset asserted mid-stream clears everything immediately. A partial match is lost and `cout` drops asynchronously.

## Structure
- Package `ex_seqdet_pkg` holds:
  - `LEN_W` = $clog2(PAT_W+1);
  - the default pattern and length constants;
  - a `cfg_t` struct {`pat`, `len`, `ovl`}.
- One sub-module is natural: `ex_seqdet_win`. It contains the history shift register, fill counter and masked comparator, and outputs `hit`.
- The top level holds the config shadow, the registered `cout` and the saturating counter.

## Test plan
- Default config after reset; stream 0,1,0,0,1 on consecutive valid cycles → one `cout` pulse one cycle after the last bit, `match_cnt` = 1.
- `cfg_load` with `pat` = 3'b101, `pat_len` = 3, `overlap_en` = 1; stream 1,0,1,0,1 → two pulses two cycles apart, `match_cnt` = 2. Repeat with `overlap_en` = 0 → one pulse, `match_cnt` = 1.
- Same 101 pattern with `cin_vld` low for 3 cycles between each bit → one pulse, after the final valid bit only.
- Send 1,0 of 101, then `cfg_load` coincident with a valid 1 → no pulse; `fill` restarts and a fresh 1,0,1 matches.
- `CNT_W` = 2, pattern "1" with `pat_len` = 1, overlap on, 6 valid 1s → six pulses, `match_cnt` saturates at 3. `cnt_clr` with a pulse → `match_cnt` = 0.
- Assert `rst_n` low after 4 of 5 default-pattern bits → outputs 0. After release the 5th bit alone produces no pulse.
